// File: rtl/alu_mc_pkg.sv
// alu_mc shared definitions: opcode map and FSM state encoding.
// Imported by alu_mc and alu_muldiv_iter.
package alu_mc_pkg;

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRA  = 4'd1;
  localparam logic [3:0] ALU_SRL  = 4'd2;
  localparam logic [3:0] ALU_MULU = 4'd3;
  localparam logic [3:0] ALU_DIVU = 4'd4;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;
  localparam logic [3:0] ALU_MULT = 4'd13;
  localparam logic [3:0] ALU_DIV  = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Ports: clk, rst (sync high); i_start loads i_a/i_b with i_div/i_signed;
// o_done marks the cycle o_lo/o_hi carry the final result (lo=prod/quot).
module alu_muldiv_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_div,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             r_act;
  logic             r_div;
  logic             r_sgn;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_dsh;
  logic [WIDTH:0]   w_dtry;
  logic             w_dok;
  logic [WIDTH-1:0] w_nhi;
  logic [WIDTH-1:0] w_nlo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_nprod;

  assign w_a_abs = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_abs = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  // mul: {hi,lo} holds partial product in hi, multiplier in lo
  assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  // div: hi is partial remainder, lo shifts dividend out / quotient in
  assign w_dsh  = {r_hi, r_lo[WIDTH-1]};
  assign w_dtry = w_dsh - {1'b0, r_b};
  assign w_dok  = !w_dtry[WIDTH];

  always_comb begin
    w_nhi = w_msum[WIDTH:1];
    w_nlo = {w_msum[0], r_lo[WIDTH-1:1]};
    if (r_div) begin
      w_nhi = w_dok ? w_dtry[WIDTH-1:0] : w_dsh[WIDTH-1:0];
      w_nlo = {r_lo[WIDTH-2:0], w_dok};
    end
  end

  assign w_prod  = {r_hi, r_lo};
  assign w_nprod = -w_prod;

  // unsigned: result is the last step's next value;
  // signed: one extra cycle applies the sign fixup
  assign o_done = r_act &&
    (r_sgn ? (r_cnt == '0) : (r_cnt == CW'(1)));

  always_comb begin
    o_lo = w_nlo;
    o_hi = w_nhi;
    if (r_sgn) begin
      if (r_div) begin
        o_lo = r_neg_q ? -r_lo : r_lo;
        o_hi = r_neg_r ? -r_hi : r_hi;
      end else begin
        o_lo = r_neg_q ? w_nprod[WIDTH-1:0] : r_lo;
        o_hi = r_neg_q ? w_nprod[2*WIDTH-1:WIDTH] : r_hi;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act   <= 1'b0;
      r_div   <= 1'b0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
    end else if (i_start) begin
      r_act   <= 1'b1;
      r_div   <= i_div;
      r_sgn   <= i_signed;
      r_neg_q <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_neg_r <= i_signed && i_a[WIDTH-1];
      r_cnt   <= CW'(WIDTH);
      r_hi    <= '0;
      r_lo    <= w_a_abs;
      r_b     <= w_b_abs;
    end else if (r_act) begin
      if (r_cnt != '0) begin
        r_hi  <= w_nhi;
        r_lo  <= w_nlo;
        r_cnt <= r_cnt - CW'(1);
      end
      if (o_done) r_act <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle MIPS ALU with valid/ready handshake and registered outputs.
// Ports: in_valid/in_ready accept ALUop,sr,tg; out_valid/out_ready
// hand over result1/result2/OF/CF/Equal; busy flags mul/div iteration.
// Option: define ALU_MC_SIGNED_MULDIV_EN for signed mult (13) / div (14).
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUop,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] tg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result1,
  output logic [WIDTH-1:0] result2,
  output logic             OF,
  output logic             CF,
  output logic             Equal,
  output logic             busy
);

  state_t r_state;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_signed;
  logic             w_div0;
  logic             w_start;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic             w_slt;
  logic             w_sltu;
  logic [WIDTH-1:0] w_r1;
  logic             w_of;
  logic             w_cf;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_lo;
  logic [WIDTH-1:0] w_md_hi;

  assign in_ready = (r_state == ST_IDLE) ||
                    (r_state == ST_DONE && out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef ALU_MC_SIGNED_MULDIV_EN
  assign w_is_mul = (ALUop == ALU_MULU) || (ALUop == ALU_MULT);
  assign w_is_div = (ALUop == ALU_DIVU) || (ALUop == ALU_DIV);
  assign w_signed = (ALUop == ALU_MULT) || (ALUop == ALU_DIV);
`else
  assign w_is_mul = (ALUop == ALU_MULU);
  assign w_is_div = (ALUop == ALU_DIVU);
  assign w_signed = 1'b0;
`endif

  assign w_div0  = w_is_div && (tg == '0);
  assign w_start = w_accept && (w_is_mul || (w_is_div && !w_div0));

  assign w_sh   = tg[SHW-1:0];
  assign w_add  = {1'b0, sr} + {1'b0, tg};
  assign w_sub  = {1'b0, sr} - {1'b0, tg};
  assign w_slt  = $signed(sr) < $signed(tg);
  assign w_sltu = sr < tg;

  always_comb begin
    w_r1 = '0;
    w_of = 1'b0;
    w_cf = 1'b0;
    unique case (ALUop)
      ALU_SLL: w_r1 = sr << w_sh;
      ALU_SRA: w_r1 = $signed(sr) >>> w_sh;
      ALU_SRL: w_r1 = sr >> w_sh;
      ALU_ADD: begin
        w_r1 = w_add[WIDTH-1:0];
        w_cf = w_add[WIDTH];
        w_of = (sr[WIDTH-1] == tg[WIDTH-1]) &&
               (w_add[WIDTH-1] != sr[WIDTH-1]);
      end
      ALU_SUB: begin
        w_r1 = w_sub[WIDTH-1:0];
        w_cf = w_sub[WIDTH];
        w_of = (sr[WIDTH-1] != tg[WIDTH-1]) &&
               (w_sub[WIDTH-1] != sr[WIDTH-1]);
      end
      ALU_AND:  w_r1 = sr & tg;
      ALU_OR:   w_r1 = sr | tg;
      ALU_XOR:  w_r1 = sr ^ tg;
      ALU_NOR:  w_r1 = ~(sr | tg);
      ALU_SLT:  w_r1 = {{(WIDTH-1){1'b0}}, w_slt};
      ALU_SLTU: w_r1 = {{(WIDTH-1){1'b0}}, w_sltu};
      default:  w_r1 = '0;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_md (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_div    (w_is_div),
    .i_signed (w_signed),
    .i_a      (sr),
    .i_b      (tg),
    .o_done   (w_md_done),
    .o_lo     (w_md_lo),
    .o_hi     (w_md_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      out_valid <= 1'b0;
      result1   <= '0;
      result2   <= '0;
      OF        <= 1'b0;
      CF        <= 1'b0;
      Equal     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            Equal <= (sr == tg);
            OF    <= 1'b0;
            CF    <= 1'b0;
            if (w_start) begin
              r_state   <= w_is_div ? ST_DIV : ST_MUL;
              out_valid <= 1'b0;
              busy      <= 1'b1;
            end else if (w_div0) begin
              r_state   <= ST_DONE;
              out_valid <= 1'b1;
              result1   <= '1;
              result2   <= sr;
              CF        <= 1'b1;
            end else begin
              r_state   <= ST_DONE;
              out_valid <= 1'b1;
              result1   <= w_r1;
              result2   <= '0;
              OF        <= w_of;
              CF        <= w_cf;
            end
          end else if (r_state == ST_DONE && out_ready) begin
            r_state   <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_md_done) begin
            r_state   <= ST_DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            result1   <= w_md_lo;
            result2   <= w_md_hi;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32).
// Random stimulus compared with an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ALUop;
  logic [W-1:0] sr;
  logic [W-1:0] tg;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result1;
  logic [W-1:0] result2;
  logic         OF;
  logic         CF;
  logic         Equal;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        of;
    logic        cf;
    int          lat;
  } exp_t;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUop     (ALUop),
    .sr        (sr),
    .tg        (tg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result1   (result1),
    .result2   (result2),
    .OF        (OF),
    .CF        (CF),
    .Equal     (Equal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    longint sa, sb, t, d, q;
    longint unsigned ua, ub;
    logic [63:0] p;
    int sh;
    e.r1 = 0; e.r2 = 0; e.of = 0; e.cf = 0; e.lat = 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(b[4:0]);
    case (op)
      4'd0: e.r1 = a << sh;
      4'd1: begin
        d = 64'sd1 <<< sh;
        t = sa / d;
        if (sa < 0 && t * d != sa) t = t - 1;
        e.r1 = t[31:0];
      end
      4'd2: e.r1 = a >> sh;
      4'd3: begin
        p = ua * ub;
        e.r1 = p[31:0]; e.r2 = p[63:32]; e.lat = 33;
      end
      4'd4: begin
        if (b == 0) begin
          e.r1 = 32'hFFFF_FFFF; e.r2 = a; e.cf = 1;
        end else begin
          e.r1 = a / b; e.r2 = a % b; e.lat = 33;
        end
      end
      4'd5: begin
        p = ua + ub;
        e.r1 = p[31:0]; e.cf = p[32];
        t = sa + sb;
        e.of = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd6: begin
        e.r1 = a - b; e.cf = (a < b);
        t = sa - sb;
        e.of = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd7:  e.r1 = a & b;
      4'd8:  e.r1 = a | b;
      4'd9:  e.r1 = a ^ b;
      4'd10: e.r1 = ~(a | b);
      4'd11: e.r1 = (sa < sb) ? 1 : 0;
      4'd12: e.r1 = (a < b) ? 1 : 0;
`ifdef ALU_MC_SIGNED_MULDIV_EN
      4'd13: begin
        t = sa * sb; p = t;
        e.r1 = p[31:0]; e.r2 = p[63:32]; e.lat = 34;
      end
      4'd14: begin
        if (b == 0) begin
          e.r1 = 32'hFFFF_FFFF; e.r2 = a; e.cf = 1;
        end else begin
          q = sa / sb; t = sa % sb;
          e.r1 = q[31:0]; e.r2 = t[31:0]; e.lat = 34;
        end
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  task automatic run_op(input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r1, output logic [31:0] r2,
                        output logic of, output logic cf,
                        output logic eq, output int lat,
                        output int busy_n);
    @(negedge clk);
    ALUop = op; sr = a; tg = b;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ALUop = 4'($urandom); sr = $urandom; tg = $urandom;
    lat = 0; busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
    end while (!out_valid && lat < 200);
    if (!out_valid) lat = -1;
    r1 = result1; r2 = result2; of = OF; cf = CF; eq = Equal;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if ({result1, result2} !== 64'h0)
      $display("FAIL reset_results got %h %h want 0 0", result1, result2);
    else n_pass++;
    n_checks++;
    if ({OF, CF, Equal} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {OF, CF, Equal});
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_add_of;
    logic [31:0] r1, r2; logic of, cf, eq; int lat, bn;
    run_op(4'd5, 32'h7FFF_FFFF, 32'h1, r1, r2, of, cf, eq, lat, bn);
    n_checks++;
    if ({r1, of, cf, eq} !== {32'h8000_0000, 3'b100})
      $display("FAIL add_of got r1=%h of=%b cf=%b eq=%b want 80000000 1 0 0", r1, of, cf, eq);
    else n_pass++;
    n_checks++;
    if (lat !== 1) $display("FAIL add_latency got %0d want 1", lat);
    else n_pass++;
  endtask

  task automatic test_mul;
    logic [31:0] r1, r2; logic of, cf, eq; int lat, bn;
    run_op(4'd3, 32'h10, 32'h4, r1, r2, of, cf, eq, lat, bn);
    n_checks++;
    if ({r1, r2} !== {32'h40, 32'h0})
      $display("FAIL mulu_result got %h %h want 40 0", r1, r2);
    else n_pass++;
    n_checks++;
    if (lat !== 33) $display("FAIL mulu_latency got %0d want 33", lat);
    else n_pass++;
    n_checks++;
    if (bn !== 32) $display("FAIL mulu_busy_cycles got %0d want 32", bn);
    else n_pass++;
  endtask

  task automatic test_div;
    logic [31:0] r1, r2; logic of, cf, eq; int lat, bn;
    run_op(4'd4, 32'h10, 32'h3, r1, r2, of, cf, eq, lat, bn);
    n_checks++;
    if ({r1, r2, lat} !== {32'h5, 32'h1, 32'd33})
      $display("FAIL divu got q=%h r=%h lat=%0d want 5 1 33", r1, r2, lat);
    else n_pass++;
    run_op(4'd4, 32'h10, 32'h0, r1, r2, of, cf, eq, lat, bn);
    n_checks++;
    if ({r1, r2, cf, lat} !== {32'hFFFF_FFFF, 32'h10, 1'b1, 32'd1})
      $display("FAIL divu_by_zero got %h %h cf=%b lat=%0d want ffffffff 10 1 1", r1, r2, cf, lat);
    else n_pass++;
  endtask

  task automatic test_signed_div;
    logic [31:0] r1, r2; logic of, cf, eq; int lat, bn;
    logic [31:0] e1, e2; int el;
`ifdef ALU_MC_SIGNED_MULDIV_EN
    e1 = 32'hFFFF_FFFD; e2 = 32'hFFFF_FFFF; el = 34;
`else
    e1 = 32'h0; e2 = 32'h0; el = 1;
`endif
    run_op(4'd14, 32'hFFFF_FFF9, 32'h2, r1, r2, of, cf, eq, lat, bn);
    n_checks++;
    if ({r1, r2, lat} !== {e1, e2, el})
      $display("FAIL op14 got %h %h lat=%0d want %h %h %0d", r1, r2, lat, e1, e2, el);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    ALUop = 4'd1; sr = 32'hF000_0000; tg = 32'h4;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, result1} !== {2'b10, 32'hFF00_0000})
        $display("FAIL bp_hold%0d got v=%b rdy=%b r1=%h want 1 0 ff000000",
                 i, out_valid, in_ready, result1);
      else n_pass++;
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    ALUop = 4'd12; sr = 32'h1; tg = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_in_ready got %b want 1", in_ready);
    else n_pass++;
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, result1} !== {1'b1, 32'h1})
      $display("FAIL bp_next_sltu got v=%b r1=%h want 1 1", out_valid, result1);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_div;
    logic [31:0] r1, r2; logic of, cf, eq; int lat, bn;
    @(negedge clk);
    ALUop = 4'd4; sr = 32'h10; tg = 32'h3;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rstdiv_busy_before got %b want 1", busy);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, result1} !== {2'b00, 32'h0})
      $display("FAIL rstdiv_after got v=%b busy=%b r1=%h want 0 0 0", out_valid, busy, result1);
    else n_pass++;
    run_op(4'd7, 32'hFF00_FF00, 32'h0F0F_0F0F, r1, r2, of, cf, eq, lat, bn);
    n_checks++;
    if ({r1, lat} !== {32'h0F00_0F00, 32'd1})
      $display("FAIL rstdiv_and got %h lat=%0d want 0f000f00 1", r1, lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [3:0]  ops[8];
    logic [31:0] as[8], bs[8];
    exp_t e;
    int pick;
    for (int i = 0; i < 8; i++) begin
      pick = $urandom_range(0, 9);
      ops[i] = (pick < 3) ? 4'(pick) : 4'(pick + 2);
      as[i] = $urandom; bs[i] = $urandom;
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    ALUop = ops[0]; sr = as[0]; tg = bs[0];
    for (int i = 0; i < 8; i++) begin
      e = model(ops[i], as[i], bs[i]);
      @(negedge clk);
      n_checks++;
      if ({out_valid, result1, result2, OF, CF} !== {1'b1, e.r1, e.r2, e.of, e.cf})
        $display("FAIL b2b%0d op=%0d got v=%b %h %h %b%b want 1 %h %h %b%b",
                 i, ops[i], out_valid, result1, result2, OF, CF,
                 e.r1, e.r2, e.of, e.cf);
      else n_pass++;
      if (i < 7) begin
        ALUop = ops[i+1]; sr = as[i+1]; tg = bs[i+1];
      end else in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_idle got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] r1, r2, a, b; logic of, cf, eq; int lat, bn;
    logic [3:0] op;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) b = a;
      if ($urandom_range(0, 3) == 0) a = {1'b1, 31'($urandom_range(0, 7))};
      e = model(op, a, b);
      run_op(op, a, b, r1, r2, of, cf, eq, lat, bn);
      n_checks++;
      if ({r1, r2, of, cf, eq} !== {e.r1, e.r2, e.of, e.cf, a == b})
        $display("FAIL rand%0d op=%0d a=%h b=%h got %h %h %b%b%b want %h %h %b%b%b",
                 i, op, a, b, r1, r2, of, cf, eq,
                 e.r1, e.r2, e.of, e.cf, a == b);
      else n_pass++;
      n_checks++;
      if (lat !== e.lat)
        $display("FAIL rand%0d_latency op=%0d got %0d want %0d", i, op, lat, e.lat);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUop = '0; sr = '0; tg = '0;
    test_reset();
    test_add_of();
    test_mul();
    test_div();
    test_signed_div();
    test_backpressure();
    test_reset_mid_div();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
